// File: rtl/relu_pkg.sv
// Shared widths, state encoding and saturation ceiling for the ReLU output stream.
package relu_pkg;

    localparam int unsigned DEF_IN_W  = 16;
    localparam int unsigned DEF_OUT_W = 8;
    localparam int unsigned DEF_CNT_W = 12;

    localparam int unsigned OUT_MAX = (1 << DEF_OUT_W) - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/relu_clip.sv
// Combinational output activation: ReLU, optional clip ceiling, then saturation to OUT_W bits.
module relu_clip
    import relu_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic             clip_en,
    input  logic [OUT_W-1:0] clip_val,
    output logic [OUT_W-1:0] act
);

    localparam logic [IN_W-1:0] SAT = (OUT_W == DEF_OUT_W) ? IN_W'(OUT_MAX)
                                                           : IN_W'((1 << OUT_W) - 1);

    logic [IN_W-1:0] clip_ext;

    assign clip_ext = {{(IN_W-OUT_W){1'b0}}, clip_val};

    // Sign bit clear means the remaining compares can be done unsigned.
    always_comb begin
        act = in_data[OUT_W-1:0];
        if (in_data[IN_W-1]) begin
            act = '0;
        end else if (clip_en && (in_data > clip_ext)) begin
            act = clip_val;
        end else if (in_data > SAT) begin
            act = '1;
        end
    end

endmodule

// File: rtl/relu_stream_ctrl.sv
// Job sequencer streaming accumulator values through relu_clip into a one-deep
// registered output stage with valid/ready on both sides.
module relu_stream_ctrl
    import relu_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cfg_clip_en,
    input  logic [OUT_W-1:0] cfg_clip_val,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] elem_cnt
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem;
    logic             clip_en_q;
    logic [OUT_W-1:0] clip_val_q;
    logic [OUT_W-1:0] act;
    logic             start_acc;
    logic             xfer;
    logic             out_hs;

    relu_clip #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_clip (
        .in_data  (in_data),
        .clip_en  (clip_en_q),
        .clip_val (clip_val_q),
        .act      (act)
    );

    assign xfer   = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        start_acc = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = (cfg_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (rem != '0) && (!out_valid || out_ready);
                if (in_valid && in_ready && (rem == CNT_W'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_valid && out_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            clip_en_q  <= 1'b0;
            clip_val_q <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            elem_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                clip_en_q  <= cfg_clip_en;
                clip_val_q <= cfg_clip_val;
                rem        <= cfg_len;
            end
            // A new transfer overwrites the stage even when the old beat handshakes now.
            if (xfer) begin
                out_data  <= act;
                out_valid <= 1'b1;
                out_last  <= (rem == CNT_W'(1));
                rem       <= rem - CNT_W'(1);
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (start_acc) begin
                elem_cnt <= '0;
            end else if (out_hs) begin
                elem_cnt <= elem_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Scoreboard bench for relu_stream_ctrl: drivers push expected beats, a negedge monitor checks them.
module tb_relu_stream_ctrl;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cfg_clip_en = 1'b0;
    logic [OUT_W-1:0] cfg_clip_val = '0;
    logic [CNT_W-1:0] cfg_len = '0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] elem_cnt;

    relu_stream_ctrl #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_clip_en  (cfg_clip_en),
        .cfg_clip_val (cfg_clip_val),
        .cfg_len      (cfg_len),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .elem_cnt     (elem_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    beat_t sb[$];
    int    vin[$];
    int    vexp[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_base = 0;
    int hs_in_job = 0;
    int first_hs = 0;
    int last_hs = 0;
    int acc_cyc = 0;
    bit bp_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // out_ready: held high, or toggled every cycle under backpressure mode
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) out_ready = ~out_ready;
            else         out_ready = 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        bit    prev_stall = 1'b0;
        logic [OUT_W+1:0] prev_vec = '0;
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", int'({out_valid, out_last, out_data}), int'(prev_vec));
                if (out_valid && !out_ready)
                    chk("stall_in_ready", int'(in_ready), 0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0d expected no beat", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", int'(out_data), int'(e.data));
                        chk("beat_last", int'(out_last), int'(e.last));
                    end
                    if (hs_in_job == 0) first_hs = cyc;
                    hs_in_job++;
                    last_hs = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_vec   = {out_valid, out_last, out_data};
                if (done) done_cnt++;
            end
        end
    end

    task automatic start_job(input int len, input bit ce, input int cv);
        @(posedge clk);
        #1;
        start        = 1'b1;
        cfg_len      = CNT_W'(len);
        cfg_clip_en  = ce;
        cfg_clip_val = OUT_W'(cv);
        hs_in_job    = 0;
        done_base    = done_cnt;
        acc_cyc      = cyc + 1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        cfg_len      = '0;
        cfg_clip_en  = 1'b0;
        cfg_clip_val = '0;
        if (len != 0) chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic feed(input int v, input int exp, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = IN_W'(v);
        sb.push_back('{data: OUT_W'(exp), last: last});
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int exp_cnt, input bit zero_len);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!done && n < 6000);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got done 0 expected 1 within 6000 cycles");
            return;
        end
        chk("done_cycle", cyc, zero_len ? acc_cyc : last_hs + 1);
        chk("done_busy", int'(busy), 0);
        chk("beats_in_job", hs_in_job, exp_cnt);
        chk("sb_empty", sb.size(), 0);
        repeat (3) @(negedge clk);
        #1;
        chk("elem_cnt", int'(elem_cnt), exp_cnt);
        chk("done_pulses", done_cnt - done_base, 1);
    endtask

    task automatic run_job(input bit ce, input int cv);
        int len = vin.size();
        start_job(len, ce, cv);
        for (int i = 0; i < len; i++) feed(vin[i], vexp[i], i == len - 1);
        in_valid = 1'b0;
        wait_done(len, len == 0);
    endtask

    initial begin
        #2;
        chk("reset_outputs",
            int'({in_ready, out_valid, out_data, out_last, busy, done, elem_cnt}), 0);
        #20;
        rst_n = 1'b1;

        // Unclipped: saturation and negative inputs
        vin = '{50, 300, -20};  vexp = '{50, 255, 0};
        run_job(1'b0, 0);

        // Clip ceiling 100
        vin = '{50, 150, 70, -10};  vexp = '{50, 100, 70, 0};
        run_job(1'b1, 100);

        // Clip ceiling 50; clip ceiling below saturation path
        vin = '{70, 30};  vexp = '{50, 30};
        run_job(1'b1, 50);
        vin = '{300, 199};  vexp = '{200, 199};
        run_job(1'b1, 200);

        // Backpressure with out_ready toggling
        bp_mode = 1'b1;
        vin = '{10, 20, 30, 40};  vexp = '{10, 20, 30, 40};
        run_job(1'b0, 0);
        bp_mode = 1'b0;

        // Zero length
        vin = {};  vexp = {};
        run_job(1'b1, 5);

        // Start while busy must be ignored (clip to 0 would corrupt data if relatched)
        start_job(5, 1'b0, 0);
        feed(1, 1, 1'b0);
        feed(2, 2, 1'b0);
        start        = 1'b1;
        cfg_len      = CNT_W'(2);
        cfg_clip_en  = 1'b1;
        cfg_clip_val = '0;
        feed(3, 3, 1'b0);
        start        = 1'b0;
        cfg_len      = '0;
        cfg_clip_en  = 1'b0;
        chk("busy_mid_job", int'(busy), 1);
        feed(4, 4, 1'b0);
        feed(5, 5, 1'b1);
        in_valid = 1'b0;
        wait_done(5, 1'b0);

        // Reset mid-job after 2 of 6 beats
        start_job(6, 1'b0, 0);
        feed(50, 50, 1'b0);
        feed(10, 10, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("midjob_beats", hs_in_job, 2);
        done_base = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            int'({in_ready, out_valid, out_data, out_last, busy, done, elem_cnt}), 0);
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", done_cnt - done_base, 0);
        rst_n = 1'b1;
        sb.delete();
        vin = '{7, 300};  vexp = '{7, 255};
        run_job(1'b0, 0);

        // Back-to-back throughput
        vin = '{1, 2, 3, 4, 5, 6, 7, 8};  vexp = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_job(1'b0, 0);
        chk("b2b_span", last_hs - first_hs, 7);

        // Maximum length: counter must reach 4095 without wrapping
        vin = {};  vexp = {};
        for (int i = 0; i < 4095; i++) begin
            vin.push_back(1000);
            vexp.push_back(255);
        end
        run_job(1'b0, 0);
        chk("max_len_span", last_hs - first_hs, 4094);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/relu_stream_ctrl.md
Name: relu_stream_ctrl

Overview:
Sequencer that streams signed 16-bit MAC accumulator results through the output activation (ReLU with optional upper clip) and delivers 8-bit activations downstream. A `start` command launches a job: it latches the clip configuration and element count for that job. The block then moves exactly that many elements with valid/ready handshakes on both sides and pulses `done`. It sits between the MAC accumulator drain and the activation write-back buffer.

Parameters:
IN_W, 16, input accumulator width (two's complement)
OUT_W, 8, output activation width (unsigned)
CNT_W, 12, element-count width (max job length 2^CNT_W-1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job launch; honoured only in IDLE
cfg_clip_en  in  1  clip enable, latched on accepted start
cfg_clip_val  in  OUT_W  clip ceiling, latched on accepted start
cfg_len  in  CNT_W  element count, latched on accepted start
in_valid  in  1  upstream accumulator value valid
in_data  in  IN_W  signed accumulator value
in_ready  out  1  block accepts in_data this cycle
out_valid  out  1  activation valid
out_data  out  OUT_W  activation value
out_last  out  1  qualifies the final element of the job
out_ready  in  1  downstream accepts out_data
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job completion
elem_cnt  out  CNT_W  elements emitted in current job

Behaviour:
- Reset: asynchronous, active-low.
  - rst_n low forces state=IDLE.
  - All outputs go to 0: in_ready, out_valid, out_data, out_last, busy, done, elem_cnt.
  - Latched config and internal counters clear.
  - Reset mid-job aborts the job; no done pulse.
- Activation function (combinational, on in_data interpreted as signed):
  - in_data < 0 -> 0.
  - Else if clip_en=1 and in_data > clip_val -> clip_val.
  - Else if in_data > 2^OUT_W-1 -> 2^OUT_W-1 (saturate).
  - Else -> in_data[OUT_W-1:0].
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches the config.
    - If cfg_len != 0 -> RUN.
    - If cfg_len == 0 -> DONE directly; no output beats.
    - busy rises the cycle after start.
  - RUN: in_ready = (rem != 0) && (!out_valid || out_ready).
    - A transfer occurs on in_valid && in_ready. On transfer, the activation is registered into out_data, out_valid=1 next cycle, and rem decrements.
    - Latency is exactly 1 cycle from input transfer to out_valid.
    - When the final element is accepted (rem 1 -> 0), out_last is set with that beat and the FSM goes to DRAIN.
  - DRAIN: in_ready=0. Hold until the last output beat handshakes (out_valid && out_ready), then -> DONE.
  - DONE: done=1 for exactly one cycle, busy=0 from this cycle, -> IDLE. start in DONE is ignored.
- Output register:
  - out_data, out_valid and out_last hold stable while out_valid && !out_ready.
  - out_valid clears on handshake unless a new input transfers in the same cycle (back-to-back throughput of 1 element/cycle).
  - Simultaneous output handshake and new input transfer: the register is overwritten with the new value and out_valid stays 1.
- elem_cnt increments on each output handshake and clears on an accepted start. It holds its final value after done until the next start.
- start while busy is ignored; the config is not re-latched and no error is flagged.
- Config inputs are sampled only on an accepted start; changes mid-job have no effect.
- Counter width: cfg_len = 2^CNT_W-1 must complete correctly with no wrap.

Decomposition:
- Shared package relu_pkg holds:
  - IN_W, OUT_W, CNT_W defaults;
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the localparam OUT_MAX = 2^OUT_W-1.
- One natural sub-module: relu_clip, the purely combinational activation function (in_data, clip_en, clip_val -> act). It is instantiated once in front of the output register.
- FSM, counters and handshake logic stay in relu_stream_ctrl.

Test Plan:
- Unclipped job: start with len=3, clip_en=0; inputs 50, 300, -20, out_ready=1.
  -> outputs 50, 255, 0; out_last on the 3rd beat; done one cycle after the last handshake; elem_cnt=3.
- Clipped job: start with len=4, clip_en=1, clip_val=100; inputs 50, 150, 70, -10.
  -> outputs 50, 100, 70, 0.
  - Repeat with clip_val=50 and input 70 -> 50.
- Backpressure: len=4, in_valid held high, out_ready toggling 1/0.
  -> out_data stable while stalled; in_ready=0 while out_valid && !out_ready; no beat lost or duplicated; 4 beats total.
- Zero length and busy start: start with len=0 -> done 1 cycle later, no out_valid.
  - start during a len=5 job -> ignored; exactly 5 beats; a single done pulse.
- Reset mid-job: rst_n asserted low after 2 of 6 beats.
  -> all outputs 0 immediately (asynchronously); no done.
  - New job len=2 afterwards -> completes normally with elem_cnt=2.
- Back-to-back throughput: len=8 with in_valid=out_ready=1 every cycle.
  -> 8 consecutive out_valid cycles; done exactly 1 cycle after the 8th output handshake.
